// File: rtl/arb_mux_reg.sv
// Registered CH-way arbitrating multiplexer with valid/ready on every input and on the output.
// The block picks the source itself (round-robin or fixed priority) and holds the winning word until it is accepted.
module arb_mux_reg #(
  parameter  int N    = 64,
  parameter  int CH   = 4,
  parameter  int PRIO = 0,
  localparam int SELW = $clog2(CH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CH-1:0]     in_valid,
  input  logic [CH*N-1:0]   in_data,
  output logic [CH-1:0]     in_ready,
  output logic              out_valid,
  output logic [N-1:0]      out_data,
  output logic [SELW-1:0]   out_sel,
  input  logic              out_ready
);

  logic            r_out_valid;
  logic [N-1:0]    r_out_data;
  logic [SELW-1:0] r_out_sel;
  logic [SELW-1:0] r_last;

  logic            w_can_load;
  logic            w_grant_any;
  logic [SELW-1:0] w_grant_idx;
  logic            w_accept;

  assign w_can_load = !r_out_valid || out_ready;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, otherwise paths that skip it infer latches.
  always_comb begin
    logic [SELW-1:0] w_cand;
    w_grant_any = 1'b0;
    w_grant_idx = '0;
    w_cand      = '0;
    if (PRIO == 1) begin
      // Walk from the top down so the lowest requesting index is written last.
      for (int i = CH - 1; i >= 0; i--) begin
        if (in_valid[i]) begin
          w_grant_any = 1'b1;
          w_grant_idx = SELW'(i);
        end
      end
    end else begin
      // Offset CH wraps to r_last itself (lowest priority); offset 1 is searched last and so wins.
      for (int k = CH; k >= 1; k--) begin
        w_cand = r_last + SELW'(k);
        if (in_valid[w_cand]) begin
          w_grant_any = 1'b1;
          w_grant_idx = w_cand;
        end
      end
    end
  end

  assign w_accept = w_grant_any && w_can_load && !reset;

  always_comb begin
    in_ready = '0;
    if (w_accept) begin
      in_ready[w_grant_idx] = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_sel   <= '0;
      r_last      <= SELW'(CH - 1);
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= in_data[w_grant_idx*N +: N];
      r_out_sel   <= w_grant_idx;
      r_last      <= w_grant_idx;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_sel   = r_out_sel;

endmodule
